// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA stream arbiter: FSM state encoding,
// round-robin index helper and the default packet length limit.
package dma_arb_pkg;

  localparam int unsigned MAXLEN_DEFAULT = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Next round-robin start index after source idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry AXI4-stream register slice (data/keep/last).
// s_ready_o is derived only from registered state, so there is no
// combinational path from m_ready_i back to the upstream side.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   s_data_i/keep_i/last_i     upstream payload
//   s_valid_i / s_ready_o      upstream handshake
//   m_data_o/keep_o/last_o     downstream payload (registered)
//   m_valid_o / m_ready_i      downstream handshake
module axis_skid_buf #(
  parameter int unsigned DW = 16,
  parameter int unsigned KW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] s_data_i,
  input  logic [KW-1:0] s_keep_i,
  input  logic          s_last_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [DW-1:0] m_data_o,
  output logic [KW-1:0] m_keep_o,
  output logic          m_last_o,
  output logic          m_valid_o,
  input  logic          m_ready_i
);

  localparam int unsigned PW = DW + KW + 1;

  logic [PW-1:0] out_q, skid_q;
  logic          out_valid_q, skid_valid_q;
  logic [PW-1:0] in_payload;

  assign in_payload = {s_keep_i, s_last_i, s_data_i};

  // Output register plus one overflow slot; skid full implies output full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (m_ready_i) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (s_valid_i) begin
      if (!out_valid_q || m_ready_i) begin
        out_q       <= in_payload;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= in_payload;
        skid_valid_q <= 1'b1;
      end
    end else if (m_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign s_ready_o = ~skid_valid_q;
  assign m_valid_o = out_valid_q;
  assign {m_keep_o, m_last_o, m_data_o} = out_q;

endmodule

// File: rtl/dma_stream_arb.sv
// dma_stream_arb: packet-granular round-robin merge of N AXI4-stream
// sources (0 = osc0, 1 = osc1, 2 = la) onto one stream toward the PS DMA.
// Packets are never interleaved; packets longer than MAXLEN beats are split
// with a forced tlast and flagged in err_len_o.
// Optional feature macro: DMA_ARB_STATS_EN adds stat_pkt_o, one 32-bit
// per-source packet counter.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_i                  per-source enable (sampled at arbitration)
//   clr_i                 clears err_len_o and statistics
//   s_t*_i / s_tready_o   packed source streams, source k at slice k
//   m_t*_o / m_tready_i   merged output stream
//   grant_o, busy_o       one-hot current owner, transfer in progress
//   err_len_o             sticky per-source truncation flag
//   stat_pkt_o            (DMA_ARB_STATS_EN) packet counters, N*32 bits
module dma_stream_arb
  import dma_arb_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned DW     = 16,
  parameter int unsigned KW     = DW / 8,
  parameter int unsigned MAXLEN = MAXLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    en_i,
  input  logic            clr_i,
  input  logic [N*DW-1:0] s_tdata_i,
  input  logic [N*KW-1:0] s_tkeep_i,
  input  logic [N-1:0]    s_tlast_i,
  input  logic [N-1:0]    s_tvalid_i,
  output logic [N-1:0]    s_tready_o,
  output logic [DW-1:0]   m_tdata_o,
  output logic [KW-1:0]   m_tkeep_o,
  output logic            m_tlast_o,
  output logic            m_tvalid_o,
  input  logic            m_tready_i,
  output logic [N-1:0]    grant_o,
  output logic            busy_o,
  output logic [N-1:0]    err_len_o
`ifdef DMA_ARB_STATS_EN
  ,
  output logic [N*32-1:0] stat_pkt_o
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(MAXLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXLEN - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [N-1:0]  err_q, err_d;

  logic [N-1:0]  req;
  logic [IW-1:0] pick;
  logic          pick_vld;
  int unsigned   idx;

  logic [DW-1:0] src_data;
  logic [KW-1:0] src_keep;
  logic          src_last, src_valid;
  logic          sb_ready, fwd_valid, accept, at_limit, pkt_end, trunc;

  // Round-robin search upward from rr_ptr with wrap-around.
  always_comb begin
    req      = s_tvalid_i & en_i;
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(rr_ptr_q) + i) % N;
      if (!pick_vld && req[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Mux the granted source onto the forwarding path.
  always_comb begin
    src_data  = '0;
    src_keep  = '0;
    src_last  = 1'b0;
    src_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_q == IW'(i)) begin
        src_data  = s_tdata_i[i*DW +: DW];
        src_keep  = s_tkeep_i[i*KW +: KW];
        src_last  = s_tlast_i[i];
        src_valid = s_tvalid_i[i];
      end
    end
  end

  assign at_limit  = (beat_cnt_q == CNT_LAST);
  assign fwd_valid = (state_q == XFER) && src_valid;
  assign accept    = fwd_valid && sb_ready;
  assign pkt_end   = accept && (src_last || at_limit);
  assign trunc     = accept && at_limit && !src_last;

  // Arbitration FSM next state.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          sel_d         = pick;
          beat_cnt_d    = '0;
          state_d       = XFER;
        end
      end
      XFER: begin
        if (accept) beat_cnt_d = beat_cnt_q + CW'(1);
        if (pkt_end) begin
          rr_ptr_d = IW'(rr_next(32'(sel_q), N));
          grant_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky truncation flags; clear wins over a same-cycle set.
  always_comb begin
    err_d = err_q;
    if (trunc) err_d[sel_q] = 1'b1;
    if (clr_i) err_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  axis_skid_buf #(.DW(DW), .KW(KW)) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_data_i  (src_data),
    .s_keep_i  (src_keep),
    .s_last_i  (src_last | at_limit),
    .s_valid_i (fwd_valid),
    .s_ready_o (sb_ready),
    .m_data_o  (m_tdata_o),
    .m_keep_o  (m_tkeep_o),
    .m_last_o  (m_tlast_o),
    .m_valid_o (m_tvalid_o),
    .m_ready_i (m_tready_i)
  );

  assign s_tready_o = grant_q & {N{sb_ready}};
  assign grant_o    = grant_q;
  assign busy_o     = (state_q == XFER);
  assign err_len_o  = err_q;

`ifdef DMA_ARB_STATS_EN
  logic [N*32-1:0] stat_q, stat_d;

  // Per-source packet-end counters, wrapping at 2^32.
  always_comb begin
    stat_d = stat_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (pkt_end && (sel_q == IW'(i))) stat_d[i*32 +: 32] = stat_q[i*32 +: 32] + 32'd1;
    end
    if (clr_i) stat_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_pkt_o = stat_q;
`endif

endmodule

// File: tb/tb_dma_stream_arb.sv
// Directed testbench for dma_stream_arb (N=3, DW=16, MAXLEN=4).
// Sources are fed from per-source beat memories; the sink logs every
// accepted output beat. Define DMA_ARB_STATS_EN to also exercise the counters.
module tb_dma_stream_arb;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  en_i;
  logic        clr_i;
  logic [47:0] s_tdata_i;
  logic [5:0]  s_tkeep_i;
  logic [2:0]  s_tlast_i, s_tvalid_i, s_tready_o;
  logic [15:0] m_tdata_o;
  logic [1:0]  m_tkeep_o;
  logic        m_tlast_o, m_tvalid_o, m_tready_i;
  logic [2:0]  grant_o, err_len_o;
  logic        busy_o;
`ifdef DMA_ARB_STATS_EN
  logic [95:0] stat_pkt_o;
`endif

  always #5 clk = ~clk;

  dma_stream_arb #(.N(3), .DW(16), .KW(2), .MAXLEN(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
    .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i), .s_tlast_i(s_tlast_i),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_tkeep_o(m_tkeep_o), .m_tlast_o(m_tlast_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_len_o(err_len_o)
`ifdef DMA_ARB_STATS_EN
    , .stat_pkt_o(stat_pkt_o)
`endif
  );

  // Beat format everywhere: {keep[1:0], last, data[15:0]}
  logic [18:0] smem [3][128];
  int          shead [3];
  int          stail [3];
  logic [2:0]  acc_pend;
  logic [18:0] olog [512];
  int          on;
  int          sink_mode;
  int          stab_viol;
  logic        prev_v, prev_r, prev_rst;
  logic [18:0] prev_beat, cur_beat;
  int          n_cmp, n_fail;

  // Source driver: retire the beat accepted at the last edge, present the next.
  initial begin
    acc_pend = '0; s_tvalid_i = '0; s_tdata_i = '0; s_tkeep_i = '0; s_tlast_i = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (acc_pend[k]) shead[k] = shead[k] + 1;
        if (shead[k] < stail[k]) begin
          s_tvalid_i[k] = 1'b1;
          {s_tkeep_i[k*2 +: 2], s_tlast_i[k], s_tdata_i[k*16 +: 16]} = smem[k][shead[k]];
        end else begin
          s_tvalid_i[k] = 1'b0;
          {s_tkeep_i[k*2 +: 2], s_tlast_i[k], s_tdata_i[k*16 +: 16]} = '0;
        end
        acc_pend[k] = s_tvalid_i[k] & s_tready_o[k] & ~rst_i;
      end
    end
  end

  // Sink: drive ready, log accepted beats, watch stalled beats for stability.
  initial begin
    m_tready_i = 1'b1; prev_v = 1'b0; prev_r = 1'b1; prev_rst = 1'b1; prev_beat = '0;
    forever begin
      @(negedge clk);
      cur_beat = {m_tkeep_o, m_tlast_o, m_tdata_o};
      if (prev_v && !prev_r && !prev_rst && (!m_tvalid_o || cur_beat != prev_beat))
        stab_viol = stab_viol + 1;
      case (sink_mode)
        1:       m_tready_i = 1'($urandom_range(0, 1));
        2:       m_tready_i = 1'b0;
        default: m_tready_i = 1'b1;
      endcase
      if (m_tvalid_o && m_tready_i && !rst_i) begin
        olog[on] = cur_beat;
        on = on + 1;
      end
      prev_v = m_tvalid_o; prev_r = m_tready_i; prev_rst = rst_i; prev_beat = cur_beat;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push(input int k, input logic [15:0] d, input logic last, input logic [1:0] keep);
    smem[k][stail[k]] = {keep, last, d};
    stail[k] = stail[k] + 1;
  endtask

  task automatic clear_bench();
    for (int k = 0; k < 3; k++) begin
      shead[k] = 0; stail[k] = 0;
    end
    acc_pend = '0; on = 0;
  endtask

  task automatic do_reset();
    step();
    rst_i = 1'b1; clr_i = 1'b0; en_i = 3'b111; sink_mode = 0; stab_viol = 0;
    clear_bench();
    step(); step();
    rst_i = 1'b0;
  endtask

  // Wait until every non-ignored source is drained and the output is empty.
  task automatic wait_idle(input logic [2:0] ign, output bit ok);
    bit pend;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      pend = 1'b0;
      for (int k = 0; k < 3; k++) if (!ign[k] && shead[k] < stail[k]) pend = 1'b1;
      if (!pend && !busy_o && !m_tvalid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL reset grant_o got %b exp 000", grant_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy_o got %b exp 0", busy_o); end
    n_cmp++; if (s_tready_o !== 3'b000) begin n_fail++; $display("FAIL reset s_tready_o got %b exp 000", s_tready_o); end
    n_cmp++; if ({m_tvalid_o, m_tlast_o, m_tkeep_o, m_tdata_o} !== 20'h0) begin
      n_fail++; $display("FAIL reset m_* got %b %b %h %h exp zeros", m_tvalid_o, m_tlast_o, m_tkeep_o, m_tdata_o);
    end
    n_cmp++; if (err_len_o !== 3'b000) begin n_fail++; $display("FAIL reset err_len_o got %b exp 000", err_len_o); end
  endtask

  task automatic test_single();
    bit ok;
    logic [18:0] e;
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 16'(b + 1), (b == 3), (b == 3) ? 2'b01 : 2'b11);
    step();
    n_cmp++; if ({grant_o, busy_o, s_tready_o, m_tvalid_o} !== 8'b001_1_001_0) begin
      n_fail++; $display("FAIL single grant latency got g=%b b=%b r=%b v=%b exp 001 1 001 0", grant_o, busy_o, s_tready_o, m_tvalid_o);
    end
    step();
    n_cmp++; if ({m_tvalid_o, m_tdata_o} !== {1'b1, 16'h0001}) begin
      n_fail++; $display("FAIL single first_out got v=%b d=%h exp 1 0001", m_tvalid_o, m_tdata_o);
    end
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || on != 4) begin n_fail++; $display("FAIL single count got %0d exp 4 (done=%0d)", on, ok); end
    for (int b = 0; b < 4 && b < on; b++) begin
      e = {(b == 3) ? 2'b01 : 2'b11, (b == 3), 16'(b + 1)};
      n_cmp++; if (olog[b] !== e) begin n_fail++; $display("FAIL single beat%0d got %h exp %h", b, olog[b], e); end
    end
    n_cmp++; if (err_len_o !== 3'b000) begin n_fail++; $display("FAIL single err_len got %b exp 000", err_len_o); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] busy_seq, vld_seq;
    do_reset();
    for (int p = 0; p < 2; p++) for (int b = 0; b < 2; b++) push(0, 16'(16'h0100 + p * 16 + b), (b == 1), 2'b11);
    for (int c = 0; c < 6; c++) begin
      step();
      busy_seq[5 - c] = busy_o;
      vld_seq[5 - c]  = m_tvalid_o;
    end
    n_cmp++; if (busy_seq !== 6'b110110) begin n_fail++; $display("FAIL b2b busy_seq got %b exp 110110", busy_seq); end
    n_cmp++; if (vld_seq !== 6'b011011) begin n_fail++; $display("FAIL b2b valid_seq got %b exp 011011", vld_seq); end
  endtask

  task automatic test_contention();
    bit ok;
    int i;
    logic [18:0] e;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 2; b++) push(k, 16'(k * 256 + p * 16 + b), (b == 1), 2'b11);
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || on != 12) begin n_fail++; $display("FAIL contention count got %0d exp 12 (done=%0d)", on, ok); end
    i = 0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 2; b++) begin
          e = {2'b11, (b == 1), 16'(k * 256 + p * 16 + b)};
          n_cmp++; if (olog[i] !== e) begin n_fail++; $display("FAIL contention beat%0d got %h exp %h", i, olog[i], e); end
          i++;
        end
  endtask

  task automatic test_enable();
    bit ok;
    int i;
    logic [18:0] e;
    do_reset();
    en_i = 3'b101;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 2; b++) push(k, 16'(16'h5000 + k * 256 + p * 16 + b), (b == 1), 2'b11);
    wait_idle(3'b010, ok);
    n_cmp++; if (!ok || on != 8) begin n_fail++; $display("FAIL enable count got %0d exp 8 (done=%0d)", on, ok); end
    i = 0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k += 2)
        for (int b = 0; b < 2; b++) begin
          e = {2'b11, (b == 1), 16'(16'h5000 + k * 256 + p * 16 + b)};
          n_cmp++; if (olog[i] !== e) begin n_fail++; $display("FAIL enable beat%0d got %h exp %h", i, olog[i], e); end
          i++;
        end
    n_cmp++; if (shead[1] != 0) begin n_fail++; $display("FAIL enable src1_taken got %0d exp 0", shead[1]); end
    // Disabling the owner mid-packet must not abort the packet.
    do_reset();
    en_i = 3'b001;
    for (int b = 0; b < 4; b++) push(0, 16'(16'h6000 + b), (b == 3), 2'b11);
    step(); step();
    en_i = 3'b000;
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || on != 4 || olog[3] !== {2'b11, 1'b1, 16'h6003}) begin
      n_fail++; $display("FAIL enable_mid count got %0d last %h exp 4 and %h", on, olog[3], {2'b11, 1'b1, 16'h6003});
    end
    push(0, 16'h6100, 1'b1, 2'b11);
    repeat (5) step();
    n_cmp++; if (busy_o !== 1'b0 || on != 4) begin n_fail++; $display("FAIL enable_off busy got %b count %0d exp 0 and 4", busy_o, on); end
  endtask

  task automatic test_truncation();
    bit ok;
    logic [18:0] e;
    do_reset();
    for (int b = 0; b < 6; b++) push(2, 16'(16'h2000 + b), (b == 5), 2'b10);
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || on != 6) begin n_fail++; $display("FAIL trunc count got %0d exp 6 (done=%0d)", on, ok); end
    for (int b = 0; b < 6; b++) begin
      e = {2'b10, (b == 3 || b == 5), 16'(16'h2000 + b)};
      n_cmp++; if (olog[b] !== e) begin n_fail++; $display("FAIL trunc beat%0d got %h exp %h", b, olog[b], e); end
    end
    n_cmp++; if (err_len_o !== 3'b100) begin n_fail++; $display("FAIL trunc err_len got %b exp 100", err_len_o); end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    n_cmp++; if (err_len_o !== 3'b000) begin n_fail++; $display("FAIL trunc clr got %b exp 000", err_len_o); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int i;
    logic [18:0] e;
    do_reset();
    sink_mode = 2;
    for (int b = 0; b < 4; b++) push(0, 16'(16'h0A00 + b), (b == 3), 2'b11);
    repeat (6) step();
    n_cmp++; if ({s_tready_o, m_tvalid_o, m_tdata_o} !== {3'b000, 1'b1, 16'h0A00}) begin
      n_fail++; $display("FAIL bp_stall got r=%b v=%b d=%h exp 000 1 0a00", s_tready_o, m_tvalid_o, m_tdata_o);
    end
    n_cmp++; if (on != 0) begin n_fail++; $display("FAIL bp_stall count got %0d exp 0", on); end
    sink_mode = 0;
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || on != 4 || olog[0] !== {2'b11, 1'b0, 16'h0A00} || olog[3] !== {2'b11, 1'b1, 16'h0A03}) begin
      n_fail++; $display("FAIL bp_release count %0d first %h last %h", on, olog[0], olog[3]);
    end
    // 25 packets of 4 beats; packet p belongs to source p%3, so RR order is p order.
    do_reset();
    sink_mode = 1;
    for (int p = 0; p < 25; p++)
      for (int b = 0; b < 4; b++) push(p % 3, 16'((p % 3) * 4096 + p * 16 + b), (b == 3), {1'b1, 1'(b)});
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || on != 100) begin n_fail++; $display("FAIL bp_rand count got %0d exp 100 (done=%0d)", on, ok); end
    i = 0;
    for (int p = 0; p < 25; p++)
      for (int b = 0; b < 4; b++) begin
        e = {1'b1, 1'(b), (b == 3), 16'((p % 3) * 4096 + p * 16 + b)};
        n_cmp++; if (olog[i] !== e) begin n_fail++; $display("FAIL bp_rand beat%0d got %h exp %h", i, olog[i], e); end
        i++;
      end
    n_cmp++; if (stab_viol != 0) begin n_fail++; $display("FAIL bp_stable violations got %0d exp 0", stab_viol); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 16'(16'h0B01 + b), (b == 3), 2'b11);
    step(); step(); step();
    rst_i = 1'b1;
    clear_bench();
    step();
    n_cmp++; if ({grant_o, busy_o, s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o, err_len_o} !== 28'h0) begin
      n_fail++; $display("FAIL rst_mid outputs got g=%b b=%b r=%b v=%b l=%b d=%h e=%b exp zeros",
                         grant_o, busy_o, s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o, err_len_o);
    end
    rst_i = 1'b0;
    on = 0;
    push(1, 16'h0C01, 1'b0, 2'b11);
    push(1, 16'h0C02, 1'b1, 2'b01);
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || on != 2 || olog[0] !== {2'b11, 1'b0, 16'h0C01} || olog[1] !== {2'b01, 1'b1, 16'h0C02}) begin
      n_fail++; $display("FAIL rst_mid fresh count %0d beats %h %h", on, olog[0], olog[1]);
    end
  endtask

`ifdef DMA_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    n_cmp++; if (stat_pkt_o !== 96'h0) begin n_fail++; $display("FAIL stats reset got %h exp 0", stat_pkt_o); end
    force dut.stat_q = {64'h0, 32'hFFFF_FFFF};
    step();
    release dut.stat_q;
    push(0, 16'h0D00, 1'b1, 2'b11);
    push(2, 16'h0D10, 1'b1, 2'b11);
    push(2, 16'h0D11, 1'b1, 2'b11);
    wait_idle(3'b000, ok);
    n_cmp++; if (!ok || stat_pkt_o !== {32'd2, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL stats wrap got %h exp %h", stat_pkt_o, {32'd2, 32'd0, 32'd0});
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    n_cmp++; if (stat_pkt_o !== 96'h0) begin n_fail++; $display("FAIL stats clr got %h exp 0", stat_pkt_o); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_fail = 0; on = 0; sink_mode = 0; stab_viol = 0;
    rst_i = 1'b1; en_i = 3'b111; clr_i = 1'b0;
    clear_bench();
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_enable();
    test_truncation();
    test_back_pressure();
    test_reset_mid();
`ifdef DMA_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_stream_arb.md
# dma_stream_arb

Packet-granular round-robin arbiter that merges the oscilloscope and logic-analyzer AXI4-stream sources (osc0, osc1, la) onto one AXI4-stream toward the PS DMA port. It sits in the PL between the acquisition blocks and the PS wrapper. It never interleaves beats of different packets, honours per-source enables, and truncates over-length packets. Output is registered through a skid buffer, so upstream timing is isolated from the PS interface.

## Interface
Parameters:
- N, 3: number of stream sources; index 0 = osc0, 1 = osc1, 2 = la.
- DW, 16: TDATA width in bits.
- KW, DW/8: TKEEP width.
- MAXLEN, 1024: maximum beats per packet; must be ≥ 2.

Ports:
- clk_i  in  1  stream clock; all logic in this single domain.
- rst_i  in  1  reset; synchronous, active-high.
- en_i  in  N  per-source enable.
- clr_i  in  1  single-cycle pulse; clears err_len_o and the statistics counters.
- s_tdata_i  in  N*DW  source data, source k at [k*DW +: DW].
- s_tkeep_i  in  N*KW  source keep.
- s_tlast_i  in  N  source last.
- s_tvalid_i  in  N  source valid.
- s_tready_o  out  N  source ready.
- m_tdata_o  out  DW  merged data.
- m_tkeep_o  out  KW  merged keep.
- m_tlast_o  out  1  merged last.
- m_tvalid_o  out  1  merged valid.
- m_tready_i  in  1  sink ready.
- grant_o  out  N  one-hot current owner; all zero in IDLE.
- busy_o  out  1  high in XFER.
- err_len_o  out  N  sticky flag per source: packet was truncated.

## Operation
- FSM states: IDLE, XFER.
- IDLE:
  - Request vector is s_tvalid_i & en_i.
  - If the vector is non-zero, grant the first set bit searching upward from rr_ptr, with wrap-around.
  - Register grant_o, clear beat_cnt, go to XFER.
  - If the vector is zero, stay in IDLE.
- XFER:
  - s_tready_o[g] = skid-buffer input ready; all other s_tready_o are 0.
  - An accepted beat (valid & ready on source g) is forwarded to the skid buffer.
  - beat_cnt increments on each accepted beat.
- Packet end is an accepted beat where s_tlast_i[g]=1 or beat_cnt == MAXLEN-1.
  - Forwarded tlast = s_tlast_i[g] | (beat_cnt == MAXLEN-1).
  - Truncation (count limit reached without source tlast) sets err_len_o[g].
  - On packet end: rr_ptr ← (g+1) mod N, grant_o ← 0, go to IDLE.
- After a truncation, the remaining beats of that source packet are treated as a new packet of the same source when they next win arbitration. No data is dropped.
- en_i is sampled only in IDLE. Deasserting en_i[g] during XFER does not abort the packet in progress.
- Data, keep and last pass through unmodified, apart from forced tlast.
- clr_i has priority over setting err_len_o in the same cycle.

## Timing
- Reset values:
  - FSM = IDLE, rr_ptr = 0.
  - grant_o = 0, busy_o = 0, s_tready_o = 0.
  - m_tvalid_o = 0; m_tdata_o, m_tkeep_o, m_tlast_o = 0.
  - err_len_o = 0; counters = 0.
  - The skid buffer is emptied.
- Reset mid-packet discards the packet in flight and any buffered beats.
- Arbitration latency: valid seen in IDLE at cycle t → grant_o and busy_o at t+1 → first s_tready_o at t+1 → first m_tvalid_o at t+2.
- Throughput:
  - One beat per cycle within a packet while m_tready_i=1.
  - Exactly one IDLE bubble cycle between packets.
- Skid buffer:
  - 2 entries.
  - s_tready_o depends only on registered state; no combinational path from m_tready_i.
  - m_tvalid_o, once high, holds with stable data/keep/last until m_tready_i.
- Back-pressure: m_tready_i low for ≥ 2 cycles drives s_tready_o low. No beat is lost or duplicated.
- Simultaneous requests from all sources with rr_ptr=0 produce grant order 0,1,2,0,…

## Configuration
- DMA_ARB_STATS_EN defined:
  - Adds output stat_pkt_o, N*32 bits.
  - One 32-bit counter per source, incremented at each packet end of that source (truncated packets included).
  - Counters wrap from 2^32-1 to 0.
  - Cleared by clr_i and rst_i.
- DMA_ARB_STATS_EN undefined: port and counters absent; all other behaviour identical.

## Structure
- Shared package dma_arb_pkg: arbitration state enum (IDLE, XFER), function for next round-robin index, default MAXLEN constant.
- Sub-module axis_skid_buf (parameters DW, KW): 2-entry register slice carrying data/keep/last. It is reusable by other stream paths.
- Arbiter FSM, beat counter, error flags and statistics live in dma_stream_arb.

## Test plan
- Single source: osc0 sends a 4-beat packet (0x0001..0x0004, tlast on beat 4), m_tready_i=1 → output beats identical; first m_tvalid_o 2 cycles after s_tvalid_i; one IDLE cycle follows.
- Contention: all three sources hold 2-beat packets continuously → grant order 0,1,2,0,1,2; no interleaving within a packet.
- Enable: en_i=3'b101 with all sources requesting → source 1 never granted. Clearing en_i[0] mid-packet → that packet still completes.
- Truncation with MAXLEN=4: la sends 6 beats with tlast on beat 6 → output packet of 4 beats with tlast forced on beat 4, err_len_o[2]=1, then a 2-beat packet. A clr_i pulse clears the flag.
- Back-pressure: m_tready_i toggling in a random 50% pattern over 100 beats → output sequence equals input sequence; m_tdata_o stable while m_tvalid_o & !m_tready_i.
- Reset mid-packet (rst_i at beat 2 of 4) → all outputs at reset values the next cycle; a fresh packet afterwards is transferred correctly. With DMA_ARB_STATS_EN: counters read 0 after reset and wrap from 0xFFFFFFFF to 0 (preloaded by force).
